// File: rtl/load_return_unit.sv
// Load return unit: accepts one load at a time, checks alignment, reads
// DataMemory, then returns the lane-selected, extended result (or a
// misaligned-load exception) on a valid/ready response channel.
module load_return_unit #(
  parameter int N           = 64,
  parameter int MEM_LATENCY = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  output logic         mem_readEnable,
  output logic [N-1:0] mem_address,
  input  logic [N-1:0] readDatabus,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         exc_valid,
  output logic         exc_StLd,
  output logic [N-1:0] exc_addr
);
  localparam int BYTES    = N / 8;
  localparam int OFFW     = $clog2(BYTES);
  localparam int CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int CNT_INIT = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [N-1:0]    maddr_q, maddr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            exc_q, exc_d;
  logic [N-1:0]    eaddr_q, eaddr_d;

  // log2 of access size; on a 32-bit datapath the doubleword codes collapse to word
  function automatic logic [1:0] size_code(input logic [2:0] f);
    size_code = f[1:0];
    if (N == 32 && f[1:0] == 2'b11) size_code = 2'b10;
  endfunction

  logic [1:0]      req_sz;
  logic [OFFW-1:0] req_mask;
  logic            req_misal;
  logic [1:0]      cap_sz;
  logic [N-1:0]    lane, keep, ext;
  logic            sbit;

  // Alignment check of the incoming request
  always_comb begin
    req_sz    = size_code(funct3);
    req_mask  = OFFW'((1 << req_sz) - 1);
    req_misal = |(addr[OFFW-1:0] & req_mask);
  end

  // Lane select and sign/zero extension of the data being captured
  always_comb begin
    cap_sz = size_code(f3_q);
    lane   = readDatabus >> {off_q, 3'b000};
    keep   = '1;
    sbit   = 1'b0;
    case (cap_sz)
      2'd0: begin keep = N'(8'hFF);        sbit = lane[7];  end
      2'd1: begin keep = N'(16'hFFFF);     sbit = lane[15]; end
      2'd2: begin keep = N'(32'hFFFF_FFFF); sbit = lane[31]; end
      default: begin keep = '1;            sbit = 1'b0;     end
    endcase
    // funct3[2] marks the unsigned variants; code 111 has full size so no extension
    ext = (lane & keep) | ({N{sbit & ~f3_q[2]}} & ~keep);
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    exc_d   = exc_q;
    eaddr_d = eaddr_q;
    case (state_q)
      IDLE: if (req_valid) begin
        f3_d    = funct3;
        off_d   = addr[OFFW-1:0];
        maddr_d = {addr[N-1:OFFW], {OFFW{1'b0}}};
        if (req_misal) begin
          state_d = RESP;
          exc_d   = 1'b1;
          eaddr_d = addr;
          data_d  = '0;
        end else begin
          state_d = READ;
          exc_d   = 1'b0;
          eaddr_d = '0;
        end
      end
      READ: begin
        if (MEM_LATENCY == 0) begin
          data_d  = ext;
          state_d = RESP;
        end else begin
          cnt_d   = CW'(CNT_INIT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      maddr_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      eaddr_q <= eaddr_d;
    end
  end

  // Outputs come from registers, forced low while reset is held
  always_comb begin
    req_ready      = ~reset & (state_q == IDLE);
    mem_readEnable = ~reset & (state_q == READ);
    mem_address    = reset ? '0 : maddr_q;
    resp_valid     = ~reset & (state_q == RESP);
    resp_data      = reset ? '0 : data_q;
    exc_valid      = ~reset & exc_q;
    exc_StLd       = 1'b0;
    exc_addr       = reset ? '0 : eaddr_q;
  end
endmodule

// File: tb/tb_load_return_unit.sv
// Directed bench: dut 0 uses a combinational memory, dut 1 a 2-cycle memory.
module tb_load_return_unit;
  localparam logic [63:0] MEM0 = 64'h80112233_44AA6677;
  localparam logic [63:0] MEM1 = 64'h01234567_89ABCDEF;

  logic        clk;
  logic        rst [2];
  logic        rv  [2];
  logic        rr  [2];
  logic [2:0]  f3  [2];
  logic [63:0] ad  [2];
  logic        re  [2];
  logic [63:0] ma  [2];
  logic [63:0] rdb [2];
  logic        pv  [2];
  logic        pr  [2];
  logic [63:0] pd  [2];
  logic        ev  [2];
  logic        es  [2];
  logic [63:0] ea  [2];

  int n_chk = 0;
  int n_err = 0;
  int re_cnt [2] = '{0, 0};
  int rv_cnt [2] = '{0, 0};
  logic [63:0] last_ma [2] = '{64'h0, 64'h0};

  load_return_unit #(.N(64), .MEM_LATENCY(0)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]),
    .funct3(f3[0]), .addr(ad[0]), .mem_readEnable(re[0]), .mem_address(ma[0]),
    .readDatabus(rdb[0]), .resp_valid(pv[0]), .resp_ready(pr[0]),
    .resp_data(pd[0]), .exc_valid(ev[0]), .exc_StLd(es[0]), .exc_addr(ea[0]));

  load_return_unit #(.N(64), .MEM_LATENCY(2)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]),
    .funct3(f3[1]), .addr(ad[1]), .mem_readEnable(re[1]), .mem_address(ma[1]),
    .readDatabus(rdb[1]), .resp_valid(pv[1]), .resp_ready(pr[1]),
    .resp_data(pd[1]), .exc_valid(ev[1]), .exc_StLd(es[1]), .exc_addr(ea[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: comb port for dut 0; dut 1 data valid only in the cycle 2 after the strobe
  logic        re1_d1, re1_d2;
  logic [63:0] ma1_d1, ma1_d2;
  initial begin re1_d1 = 0; re1_d2 = 0; ma1_d1 = 0; ma1_d2 = 0; end
  always @(posedge clk) begin
    re1_d1 <= re[1]; ma1_d1 <= ma[1];
    re1_d2 <= re1_d1; ma1_d2 <= ma1_d1;
  end
  assign rdb[0] = ma[0][3] ? MEM1 : MEM0;
  assign rdb[1] = re1_d2 ? (ma1_d2[3] ? MEM1 : MEM0) : 64'hDEAD_BEEF_DEAD_BEEF;

  // activity monitors
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (re[d]) begin
        re_cnt[d]  <= re_cnt[d] + 1;
        last_ma[d] <= ma[d];
      end
      if (pv[d]) rv_cnt[d] <= rv_cnt[d] + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic all_zero(input int d, input string nm);
    chk({nm, "/req_ready"}, 64'(rr[d]), 0);
    chk({nm, "/mem_re"},    64'(re[d]), 0);
    chk({nm, "/mem_addr"},  ma[d], 0);
    chk({nm, "/resp_vld"},  64'(pv[d]), 0);
    chk({nm, "/resp_data"}, pd[d], 0);
    chk({nm, "/exc_vld"},   64'(ev[d]), 0);
    chk({nm, "/exc_stld"},  64'(es[d]), 0);
    chk({nm, "/exc_addr"},  ea[d], 0);
  endtask

  // one complete load; lat = negedges after the accepting edge until resp_valid
  task automatic run(input int d, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] ed, input logic ee, input logic [63:0] ema,
                     input string nm);
    int w, lat, re0, ml;
    ml = (d == 0) ? 0 : 2;
    w = 0;
    while (!rr[d] && w < 50) begin @(negedge clk); w++; end
    chk({nm, "/req_ready"}, 64'(rr[d]), 1);
    re0 = re_cnt[d];
    rv[d] = 1'b1; f3[d] = f; ad[d] = a;
    @(negedge clk);
    rv[d] = 1'b0; f3[d] = ~f; ad[d] = ~a;
    lat = 0;
    while (!pv[d] && lat < 50) begin @(negedge clk); lat++; end
    chk({nm, "/latency"},   64'(lat), ee ? 64'd0 : 64'(1 + ml));
    chk({nm, "/resp_data"}, pd[d], ed);
    chk({nm, "/exc_vld"},   64'(ev[d]), 64'(ee));
    chk({nm, "/exc_addr"},  ea[d], ee ? a : 64'h0);
    chk({nm, "/exc_stld"},  64'(es[d]), 0);
    chk({nm, "/mem_reads"}, 64'(re_cnt[d] - re0), ee ? 64'd0 : 64'd1);
    if (!ee) chk({nm, "/mem_addr"}, last_ma[d], ema);
    pr[d] = 1'b1;
    @(negedge clk);
    pr[d] = 1'b0;
    chk({nm, "/done"}, 64'(pv[d]), 0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] d;
    logic        e;
    logic [63:0] ma;
  } vec_t;

  vec_t vt [18];
  logic [63:0] snap_d;
  int rvc;

  initial begin
    vt[0]  = '{3'b000, 64'd2,  64'hFFFFFFFF_FFFFFFAA, 1'b0, 64'd0};
    vt[1]  = '{3'b100, 64'd2,  64'h00000000_000000AA, 1'b0, 64'd0};
    vt[2]  = '{3'b010, 64'd4,  64'hFFFFFFFF_80112233, 1'b0, 64'd0};
    vt[3]  = '{3'b110, 64'd4,  64'h00000000_80112233, 1'b0, 64'd0};
    vt[4]  = '{3'b001, 64'd6,  64'hFFFFFFFF_FFFF8011, 1'b0, 64'd0};
    vt[5]  = '{3'b011, 64'd0,  64'h80112233_44AA6677, 1'b0, 64'd0};
    vt[6]  = '{3'b010, 64'd2,  64'h0,                 1'b1, 64'd0};
    vt[7]  = '{3'b001, 64'd1,  64'h0,                 1'b1, 64'd0};
    vt[8]  = '{3'b000, 64'd7,  64'hFFFFFFFF_FFFFFF80, 1'b0, 64'd0};
    vt[9]  = '{3'b100, 64'd7,  64'h00000000_00000080, 1'b0, 64'd0};
    vt[10] = '{3'b101, 64'd2,  64'h00000000_000044AA, 1'b0, 64'd0};
    vt[11] = '{3'b001, 64'd2,  64'h00000000_000044AA, 1'b0, 64'd0};
    vt[12] = '{3'b011, 64'd4,  64'h0,                 1'b1, 64'd0};
    vt[13] = '{3'b111, 64'd0,  64'h80112233_44AA6677, 1'b0, 64'd0};
    vt[14] = '{3'b111, 64'd4,  64'h0,                 1'b1, 64'd0};
    vt[15] = '{3'b000, 64'd9,  64'hFFFFFFFF_FFFFFFCD, 1'b0, 64'd8};
    vt[16] = '{3'b010, 64'd8,  64'hFFFFFFFF_89ABCDEF, 1'b0, 64'd8};
    vt[17] = '{3'b110, 64'd12, 64'h00000000_01234567, 1'b0, 64'd8};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; pr[d] = 1'b0; f3[d] = '0; ad[d] = '0;
    end
    repeat (3) @(negedge clk);
    all_zero(0, "reset0");
    all_zero(1, "reset1");
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("post_reset0/req_ready", 64'(rr[0]), 1);
    chk("post_reset1/req_ready", 64'(rr[1]), 1);
    @(negedge clk);

    // table of single loads on the combinational-memory unit
    for (int i = 0; i < 18; i++)
      run(0, vt[i].f, vt[i].a, vt[i].d, vt[i].e, vt[i].ma, $sformatf("vec%0d", i));

    // two-cycle memory unit
    run(1, 3'b101, 64'd0,  64'h00000000_00006677, 1'b0, 64'd0, "lat2_lhu0");
    run(1, 3'b010, 64'd12, 64'h00000000_01234567, 1'b0, 64'd8, "lat2_lw12");
    run(1, 3'b001, 64'd1,  64'h0,                 1'b1, 64'd0, "lat2_lh1");

    // backpressure: held response, pending request accepted right after handshake
    rv[0] = 1'b1; f3[0] = 3'b011; ad[0] = 64'd0;
    @(negedge clk);
    f3[0] = 3'b100; ad[0] = 64'd7;
    @(negedge clk);
    chk("bp/resp_vld", 64'(pv[0]), 1);
    chk("bp/resp_data", pd[0], MEM0);
    snap_d = pd[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d/resp_vld", k), 64'(pv[0]), 1);
      chk($sformatf("bp_hold%0d/resp_data", k), pd[0], snap_d);
      chk($sformatf("bp_hold%0d/exc", k), {ea[0][62:0], ev[0]}, 64'h0);
      chk($sformatf("bp_hold%0d/req_ready", k), 64'(rr[0]), 0);
    end
    pr[0] = 1'b1;
    @(negedge clk);
    pr[0] = 1'b0;
    chk("bp_after/req_ready", 64'(rr[0]), 1);
    chk("bp_after/resp_vld", 64'(pv[0]), 0);
    @(negedge clk);
    rv[0] = 1'b0;
    chk("bp_next/mem_re", 64'(re[0]), 1);
    @(negedge clk);
    chk("bp_next/resp_vld", 64'(pv[0]), 1);
    chk("bp_next/resp_data", pd[0], 64'h80);
    pr[0] = 1'b1;
    @(negedge clk);
    pr[0] = 1'b0;

    // reset during READ, then during WAIT on the two-cycle unit
    rvc = rv_cnt[1];
    rv[1] = 1'b1; f3[1] = 3'b011; ad[1] = 64'd0;
    @(negedge clk);
    rv[1] = 1'b0;
    chk("rst_read/mem_re", 64'(re[1]), 1);
    rst[1] = 1'b1;
    @(negedge clk);
    all_zero(1, "rst_read");
    rst[1] = 1'b0;
    #1;
    chk("rst_read/req_ready_after", 64'(rr[1]), 1);
    rv[1] = 1'b1; f3[1] = 3'b011; ad[1] = 64'd0;
    @(negedge clk);
    rv[1] = 1'b0;
    @(negedge clk);
    chk("rst_wait/mem_re", 64'(re[1]), 0);
    chk("rst_wait/resp_vld", 64'(pv[1]), 0);
    rst[1] = 1'b1;
    @(negedge clk);
    all_zero(1, "rst_wait");
    rst[1] = 1'b0;
    #1;
    chk("rst_wait/req_ready_after", 64'(rr[1]), 1);
    repeat (6) @(negedge clk);
    chk("rst/no_response", 64'(rv_cnt[1] - rvc), 0);
    run(1, 3'b011, 64'd0, MEM0, 1'b0, 64'd0, "rst_then_ld");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
